// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, FALU op codes, fflags indices and FSM state type for the FP issue stage
package fpu_pkg;

  localparam logic [4:0] FUNCT5_FADD = 5'b00000;
  localparam logic [4:0] FUNCT5_FSUB = 5'b00001;
  localparam logic [4:0] FUNCT5_FMUL = 5'b00010;
  localparam logic [4:0] FUNCT5_FDIV = 5'b00011;

  localparam logic [3:0] FALU_ADD  = 4'd0;
  localparam logic [3:0] FALU_MUL  = 4'd1;
  localparam logic [3:0] FALU_DIV  = 4'd2;
  localparam logic [3:0] FALU_SUB  = 4'd3;
  localparam logic [3:0] FALU_NONE = 4'd15;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_ILLEGAL
  } issue_state_e;

endpackage

// File: rtl/fpu_flag_accum.sv
// rtl/fpu_flag_accum.sv - sticky fflags register; a clear and a set in the same cycle keep the new flags
module fpu_flag_accum (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clr_i,
  input  logic       set_i,
  input  logic [4:0] flags_i,
  output logic [4:0] fflags_o
);

  logic [4:0] flags_q;
  logic [4:0] flags_d;

  always_comb begin
    flags_d = clr_i ? 5'd0 : flags_q;
    if (set_i) flags_d = flags_d | flags_i;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) flags_q <= 5'd0;
    else       flags_q <= flags_d;
  end

  assign fflags_o = flags_q;

endmodule

// File: rtl/fpu_issue_stage.sv
// rtl/fpu_issue_stage.sv - decodes FP ops, holds FALU operands for a per-op settle window and captures results
module fpu_issue_stage #(
  parameter int ADD_CYCLES = 2,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 6,
  parameter int CNT_W      = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic [4:0]  funct5,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic        fflags_clr,
  output logic [31:0] falu_a,
  output logic [31:0] falu_b,
  output logic [3:0]  falu_op,
  input  logic [31:0] falu_result,
  input  logic        falu_exc,
  input  logic        falu_ovf,
  input  logic        falu_unf,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic [4:0]  rd_out,
  output logic        stall,
  output logic [4:0]  fflags
);

  import fpu_pkg::*;

  issue_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q, res_q;
  logic [3:0]       op_q;
  logic [4:0]       rd_q, rd_out_q;
  logic             rv_q;

  logic             dec_legal;
  logic [3:0]       dec_op;
  logic [CNT_W-1:0] dec_cnt;
  logic             capture;
  logic             div_by_zero;
  logic [4:0]       new_flags;

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = FALU_ADD;
    dec_cnt   = CNT_W'(ADD_CYCLES - 1);
    case (funct5)
      FUNCT5_FADD: begin dec_op = FALU_ADD; dec_cnt = CNT_W'(ADD_CYCLES - 1); end
      FUNCT5_FSUB: begin dec_op = FALU_SUB; dec_cnt = CNT_W'(ADD_CYCLES - 1); end
      FUNCT5_FMUL: begin dec_op = FALU_MUL; dec_cnt = CNT_W'(MUL_CYCLES - 1); end
      FUNCT5_FDIV: begin dec_op = FALU_DIV; dec_cnt = CNT_W'(DIV_CYCLES - 1); end
      default:     dec_legal = 1'b0;
    endcase
  end

  assign capture = ~flush & (((state_q == ST_EXEC) && (cnt_q == '0)) || (state_q == ST_ILLEGAL));

  // Finite non-zero dividend over a zero divisor is DZ; the FALU's generic exception must not also raise NV.
  assign div_by_zero = (op_q == FALU_DIV) && (b_q[30:0] == 31'd0) &&
                       (a_q[30:23] != 8'hFF) && (a_q[30:0] != 31'd0);

  always_comb begin
    new_flags = 5'd0;
    if (state_q == ST_ILLEGAL) begin
      new_flags[FF_NV] = 1'b1;
    end else begin
      new_flags[FF_NV] = falu_exc & ~div_by_zero;
      new_flags[FF_DZ] = div_by_zero;
      new_flags[FF_OF] = falu_ovf;
      new_flags[FF_UF] = falu_unf;
      new_flags[FF_NX] = falu_ovf | falu_unf;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= FALU_NONE;
      rd_q     <= 5'd0;
      rd_out_q <= 5'd0;
      res_q    <= 32'd0;
      rv_q     <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        op_q    <= FALU_NONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (valid_in) begin
              rd_q <= rd_in;
              if (dec_legal) begin
                a_q     <= rs1_data;
                b_q     <= rs2_data;
                op_q    <= dec_op;
                cnt_q   <= dec_cnt;
                state_q <= ST_EXEC;
              end else begin
                state_q <= ST_ILLEGAL;
              end
            end
          end
          ST_EXEC: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              res_q    <= falu_result;
              rd_out_q <= rd_q;
              rv_q     <= 1'b1;
              op_q     <= FALU_NONE;
              state_q  <= ST_IDLE;
            end
          end
          ST_ILLEGAL: begin
            res_q    <= CANON_NAN;
            rd_out_q <= rd_q;
            rv_q     <= 1'b1;
            state_q  <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  fpu_flag_accum u_flag_accum (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr_i    (fflags_clr),
    .set_i    (capture),
    .flags_i  (new_flags),
    .fflags_o (fflags)
  );

  assign in_ready     = (state_q == ST_IDLE);
  assign stall        = valid_in & ~in_ready;
  assign falu_a       = a_q;
  assign falu_b       = b_q;
  assign falu_op      = op_q;
  assign result_valid = rv_q;
  assign result_data  = res_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// tb/tb_fpu_issue_stage.sv - scoreboard bench for fpu_issue_stage with a table-driven FALU stand-in
module tb_fpu_issue_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        valid_in, in_ready, flush, fflags_clr;
  logic [4:0]  funct5, rd_in, rd_out, fflags;
  logic [31:0] rs1_data, rs2_data, falu_a, falu_b, falu_result, result_data;
  logic [3:0]  falu_op;
  logic        falu_exc, falu_ovf, falu_unf, result_valid, stall;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic [4:0]  f;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fpu_issue_stage dut (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in), .in_ready(in_ready),
    .funct5(funct5), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .flush(flush), .fflags_clr(fflags_clr), .falu_a(falu_a), .falu_b(falu_b),
    .falu_op(falu_op), .falu_result(falu_result), .falu_exc(falu_exc),
    .falu_ovf(falu_ovf), .falu_unf(falu_unf), .result_valid(result_valid),
    .result_data(result_data), .rd_out(rd_out), .stall(stall), .fflags(fflags)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Known IEEE-754 results for the vectors used below; anything else yields a poison value.
  always_comb begin
    falu_result = 32'hBAD0BAD0;
    falu_exc = 1'b0;
    falu_ovf = 1'b0;
    falu_unf = 1'b0;
    case ({falu_op, falu_a, falu_b})
      {4'd0, 32'h3FC00000, 32'h40100000}: falu_result = 32'h40700000;
      {4'd0, 32'h40000000, 32'h40000000}: falu_result = 32'h40800000;
      {4'd1, 32'h40400000, 32'h40000000}: falu_result = 32'h40C00000;
      {4'd3, 32'h40400000, 32'h3F800000}: falu_result = 32'h40000000;
      {4'd2, 32'h3F800000, 32'h00000000}: begin falu_result = 32'h7F800000; falu_exc = 1'b1; end
      {4'd1, 32'h7F000000, 32'h40000000}: begin falu_result = 32'h7F800000; falu_ovf = 1'b1; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_data", result_data, e.d);
        chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        chk("fflags", {27'd0, fflags}, {27'd0, e.f});
        chk("latency", cyc, e.cyc);
        chk("ready_at_result", {31'd0, in_ready}, 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_res, input logic [31:0] exp_d,
                       input logic [4:0] exp_f, input int lat);
    int   n;
    exp_t e;
    valid_in = 1'b1;
    funct5   = f5;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    n = 0;
    while (!in_ready && n < 20) begin
      chk("stall", {31'd0, stall}, 32'd1);
      @(negedge CLK);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    if (n > 0) chk("b2b_accept_in_result_cycle", {31'd0, result_valid}, 32'd1);
    if (expect_res) begin
      e.d = exp_d; e.rd = rd; e.f = exp_f; e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge CLK);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; valid_in = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    funct5 = 5'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_falu_op", {28'd0, falu_op}, 32'd15);
    chk("rst_result_data", result_data, 32'd0);
    chk("rst_fflags", {27'd0, fflags}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    issue(5'b00000, 32'h3FC00000, 32'h40100000, 5'd1, 1, 32'h40700000, 5'b00000, 2);
    issue(5'b00000, 32'h3FC00000, 32'h40100000, 5'd2, 1, 32'h40700000, 5'b00000, 2);
    issue(5'b00010, 32'h40400000, 32'h40000000, 5'd3, 1, 32'h40C00000, 5'b00000, 3);
    issue(5'b00001, 32'h40400000, 32'h3F800000, 5'd4, 1, 32'h40000000, 5'b00000, 2);
    issue(5'b00001, 32'h40400000, 32'h3F800000, 5'd5, 1, 32'h40000000, 5'b00000, 2);
    issue(5'b00011, 32'h3F800000, 32'h00000000, 5'd6, 1, 32'h7F800000, 5'b01000, 6);
    issue(5'b00111, 32'h12345678, 32'h9ABCDEF0, 5'd7, 1, 32'h7FC00000, 5'b11000, 1);

    // Clear coincides with the FDIV capture edge: NV goes, the new DZ stays.
    issue(5'b00011, 32'h3F800000, 32'h00000000, 5'd8, 1, 32'h7F800000, 5'b01000, 6);
    repeat (5) @(negedge CLK);
    fflags_clr = 1'b1;
    @(negedge CLK);
    fflags_clr = 1'b0;
    drain();

    fflags_clr = 1'b1;
    @(negedge CLK);
    fflags_clr = 1'b0;
    chk("clr_alone", {27'd0, fflags}, 32'd0);
    issue(5'b00010, 32'h7F000000, 32'h40000000, 5'd9, 1, 32'h7F800000, 5'b00101, 3);
    drain();

    issue(5'b00011, 32'h3F800000, 32'h00000000, 5'd10, 0, 32'd0, 5'd0, 6);
    repeat (2) @(negedge CLK);
    flush = 1'b1;
    valid_in = 1'b1; funct5 = 5'b00000; rs1_data = 32'h40000000; rs2_data = 32'h40000000;
    @(negedge CLK);
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_fflags", {27'd0, fflags}, 32'h05);
    chk("flush_result_data", result_data, 32'h7F800000);
    chk("flush_falu_op", {28'd0, falu_op}, 32'd15);
    repeat (8) @(negedge CLK);
    chk("flush_still_idle", {31'd0, in_ready}, 32'd1);
    issue(5'b00000, 32'h40000000, 32'h40000000, 5'd11, 1, 32'h40800000, 5'b00101, 2);
    drain();

    issue(5'b00011, 32'h3F800000, 32'h00000000, 5'd12, 0, 32'd0, 5'd0, 6);
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("arst_result_data", result_data, 32'd0);
    chk("arst_fflags", {27'd0, fflags}, 32'd0);
    chk("arst_falu_op", {28'd0, falu_op}, 32'd15);
    chk("arst_falu_a", falu_a, 32'd0);
    chk("arst_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (8) @(negedge CLK);
    chk("post_rst_idle", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
